// File: rtl/tia568b_pkg.sv
// Shared definitions for the TIA-568B pair transmit path.
//   - tx_state_t  : transmit framing states
//   - mlt_level_t : three-level line state used by the MLT-3 driver
//   - CODE_*      : 5-bit control symbols (line order is MSB first)
//   - enc_4b5b()  : nibble to 5-bit data symbol
package tia568b_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SSD_J,
        SSD_K,
        DATA_LO,
        DATA_HI,
        HALT,
        ESD_T,
        ESD_R
    } tx_state_t;

    typedef enum logic [1:0] {
        ZERO,
        POS,
        NEG
    } mlt_level_t;

    localparam logic [4:0] CODE_IDLE = 5'b11111;
    localparam logic [4:0] CODE_J    = 5'b11000;
    localparam logic [4:0] CODE_K    = 5'b10001;
    localparam logic [4:0] CODE_T    = 5'b01101;
    localparam logic [4:0] CODE_R    = 5'b00111;
    localparam logic [4:0] CODE_HALT = 5'b00100;

    function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
        logic [4:0] code;
        case (nib)
            4'h0: code = 5'b11110;
            4'h1: code = 5'b01001;
            4'h2: code = 5'b10100;
            4'h3: code = 5'b10101;
            4'h4: code = 5'b01010;
            4'h5: code = 5'b01011;
            4'h6: code = 5'b01110;
            4'h7: code = 5'b01111;
            4'h8: code = 5'b10010;
            4'h9: code = 5'b10011;
            4'hA: code = 5'b10110;
            4'hB: code = 5'b10111;
            4'hC: code = 5'b11010;
            4'hD: code = 5'b11011;
            4'hE: code = 5'b11100;
            default: code = 5'b11101;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tia568b_pair_tx_encoder_mlt3.sv
// MLT-3 line driver for one twisted pair.
// Each strobe with bit_in=1 steps the level 0 -> +1 -> 0 -> -1 -> 0;
// bit_in=0 holds it. Reusable for any pair of the cable.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (level -> 0)
//   strobe  : one-cycle bit strobe
//   bit_in  : serial bit presented on the strobe cycle
//   line_p  : high while level is +1
//   line_n  : high while level is -1 (never together with line_p)
module mlt3_line_driver
    import tia568b_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic bit_in,
    output logic line_p,
    output logic line_n
);

    mlt_level_t level;
    // Direction to take when leaving zero; alternates so the line
    // visits +1 and -1 in turn.
    logic       next_pos;

    // NOTE: state registers use non-blocking assignments so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= ZERO;
            next_pos <= 1'b1;
        end else if (strobe && bit_in) begin
            case (level)
                ZERO: level <= next_pos ? POS : NEG;
                POS: begin
                    level    <= ZERO;
                    next_pos <= 1'b0;
                end
                default: begin
                    level    <= ZERO;
                    next_pos <= 1'b1;
                end
            endcase
        end
    end

    assign line_p = (level == POS);
    assign line_n = (level == NEG);

endmodule

// File: rtl/tia568b_pair_tx_encoder.sv
// Transmit line encoder for one TIA-568B pair.
// Bytes arrive on a valid/ready handshake, are framed J K <data> T R,
// 4B5B-encoded low nibble first, serialised MSB first and driven as MLT-3.
// IDLE (11111) is streamed between frames.
//   Clock100Mhz : sole clock
//   Reset       : synchronous active-high reset
//   InData      : byte to transmit
//   InValid     : InData valid
//   InLast      : InData is the final byte of the frame
//   InReady     : byte taken on a cycle with InValid & InReady
//   LineP/LineN : MLT-3 level (+1 = 1/0, -1 = 0/1, 0 = 0/0)
//   TxActive    : high from the first J bit through the last R bit
//   Underrun    : one-cycle pulse when a mid-frame byte was missing
//   TxBitMon    : serial bit currently on the line, before MLT-3
module tia568b_pair_tx_encoder
    import tia568b_pkg::*;
#(
    parameter int BIT_DIV          = 1,
    parameter int MIN_IDLE_SYMBOLS = 2
) (
    input  logic       Clock100Mhz,
    input  logic       Reset,
    input  logic [7:0] InData,
    input  logic       InValid,
    input  logic       InLast,
    output logic       InReady,
    output logic       LineP,
    output logic       LineN,
    output logic       TxActive,
    output logic       Underrun,
    output logic       TxBitMon
);

    localparam logic [3:0] DIV_LAST = 4'(BIT_DIV - 1);
    localparam logic [3:0] IDLE_MIN = 4'(MIN_IDLE_SYMBOLS);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [3:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] idle_cnt;
    logic [3:0] idle_done;
    logic [7:0] byte_q;
    logic       last_q;
    logic [4:0] code;
    logic       cur_bit;
    logic       strobe;
    logic       boundary;
    logic       accept_win;

    assign strobe   = (div_cnt == DIV_LAST);
    assign boundary = strobe && (bit_cnt == 3'd4);

    // Idle symbols completed including the one ending now (saturating).
    assign idle_done = (idle_cnt == 4'hF) ? 4'hF : idle_cnt + 4'd1;

    // A byte is requested only where the next symbol must be data.
    assign accept_win = (state == SSD_K) || ((state == DATA_HI) && !last_q);
    assign InReady    = !Reset && boundary && accept_win;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        code      = CODE_IDLE;
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((idle_done >= IDLE_MIN) && InValid)
                    state_nxt = SSD_J;
            end
            SSD_J: begin
                code      = CODE_J;
                state_nxt = SSD_K;
            end
            SSD_K: begin
                code      = CODE_K;
                state_nxt = InValid ? DATA_LO : HALT;
            end
            DATA_LO: begin
                code      = enc_4b5b(byte_q[3:0]);
                state_nxt = DATA_HI;
            end
            DATA_HI: begin
                code = enc_4b5b(byte_q[7:4]);
                if (last_q)
                    state_nxt = ESD_T;
                else
                    state_nxt = InValid ? DATA_LO : HALT;
            end
            HALT: begin
                code      = CODE_HALT;
                state_nxt = ESD_T;
            end
            ESD_T: begin
                code      = CODE_T;
                state_nxt = ESD_R;
            end
            default: begin
                code      = CODE_R;
                state_nxt = IDLE;
            end
        endcase
    end

    assign cur_bit = code[3'd4 - bit_cnt];

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= IDLE;
            idle_cnt <= '0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            TxBitMon <= 1'b1;
            TxActive <= 1'b0;
            Underrun <= 1'b0;
        end else begin
            Underrun <= 1'b0;
            if (strobe) begin
                div_cnt  <= '0;
                bit_cnt  <= (bit_cnt == 3'd4) ? 3'd0 : bit_cnt + 3'd1;
                // Line bit and activity flag move together so TxActive
                // frames exactly the J..R bits seen on the wire.
                TxBitMon <= cur_bit;
                TxActive <= (state != IDLE);
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
            if (boundary) begin
                state <= state_nxt;
                if (state == IDLE)
                    idle_cnt <= idle_done;
                else if (state == ESD_R)
                    idle_cnt <= '0;
                if (accept_win && InValid) begin
                    byte_q <= InData;
                    last_q <= InLast;
                end
                if (accept_win && !InValid)
                    Underrun <= 1'b1;
            end
        end
    end

    mlt3_line_driver u_mlt3 (
        .clk    (Clock100Mhz),
        .rst    (Reset),
        .strobe (strobe),
        .bit_in (cur_bit),
        .line_p (LineP),
        .line_n (LineN)
    );

endmodule

// File: tb/tb_tia568b_pair_tx_encoder.sv
// Directed bench for tia568b_pair_tx_encoder: instance A (BIT_DIV=1) and
// instance B (BIT_DIV=3). Every cycle's outputs are logged into history
// vectors, then each scenario is checked against hand-derived streams.
module tb_tia568b_pair_tx_encoder;

    localparam int HW = 1024;

    localparam logic [4:0] S_J = 5'b11000;
    localparam logic [4:0] S_K = 5'b10001;
    localparam logic [4:0] S_T = 5'b01101;
    localparam logic [4:0] S_R = 5'b00111;
    localparam logic [4:0] S_H = 5'b00100;
    localparam logic [29:0] FRAME_5A   = {S_J, S_K, 5'b10110, 5'b01011, S_T, S_R};
    localparam logic [39:0] FRAME_00FF = {S_J, S_K, 5'b11110, 5'b11110, 5'b11101, 5'b11101, S_T, S_R};
    localparam logic [34:0] FRAME_12U  = {S_J, S_K, 5'b10100, 5'b01001, S_H, S_T, S_R};

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic       clk = 1'b0;
    logic       rst_a, valid_a, last_a, ready_a, p_a, n_a, act_a, und_a, bit_a;
    logic [7:0] data_a;
    logic       rst_b, valid_b, last_b, ready_b, p_b, n_b, act_b, und_b, bit_b;
    logic [7:0] data_b;

    logic [HW-1:0] h_bit_a, h_p_a, h_n_a, h_act_a, h_und_a, h_rdy_a;
    logic [HW-1:0] h_bit_b, h_p_b, h_n_b, h_act_b, h_rdy_b;

    byte_t q_a[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    tia568b_pair_tx_encoder #(.BIT_DIV(1), .MIN_IDLE_SYMBOLS(2)) dut_a (
        .Clock100Mhz (clk),
        .Reset       (rst_a),
        .InData      (data_a),
        .InValid     (valid_a),
        .InLast      (last_a),
        .InReady     (ready_a),
        .LineP       (p_a),
        .LineN       (n_a),
        .TxActive    (act_a),
        .Underrun    (und_a),
        .TxBitMon    (bit_a)
    );

    tia568b_pair_tx_encoder #(.BIT_DIV(3), .MIN_IDLE_SYMBOLS(2)) dut_b (
        .Clock100Mhz (clk),
        .Reset       (rst_b),
        .InData      (data_b),
        .InValid     (valid_b),
        .InLast      (last_b),
        .InReady     (ready_b),
        .LineP       (p_b),
        .LineN       (n_b),
        .TxActive    (act_b),
        .Underrun    (und_b),
        .TxBitMon    (bit_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed_a();
        valid_a = (q_a.size() > 0);
        data_a  = valid_a ? q_a[0].d : 8'h00;
        last_a  = valid_a ? q_a[0].l : 1'b0;
    endtask

    // One clock: InReady is logged mid-cycle (index = the edge it precedes),
    // outputs 1 time unit after the edge, then inputs are updated.
    task automatic step();
        logic hs_a, hs_b;
        if (cyc >= HW - 1) begin
            $display("FAIL cycle_budget: observed %0d cycles limit %0d", cyc, HW - 1);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
        h_rdy_a[cyc] = ready_a;
        h_rdy_b[cyc] = ready_b;
        hs_a = ready_a && valid_a;
        hs_b = ready_b && valid_b;
        @(posedge clk);
        #1;
        h_bit_a[cyc] = bit_a;  h_p_a[cyc] = p_a;  h_n_a[cyc] = n_a;
        h_act_a[cyc] = act_a;  h_und_a[cyc] = und_a;
        h_bit_b[cyc] = bit_b;  h_p_b[cyc] = p_b;  h_n_b[cyc] = n_b;
        h_act_b[cyc] = act_b;
        cyc++;
        if (hs_a) void'(q_a.pop_front());
        if (hs_b) valid_b = 1'b0;
        feed_a();
    endtask

    function automatic int find_first(input logic [HW-1:0] h, input int from, input int to);
        for (int c = from; c < to; c++)
            if (h[c]) return c;
        return -1;
    endfunction

    function automatic int count_ones(input logic [HW-1:0] h, input int from, input int to);
        int n = 0;
        for (int c = from; c < to; c++)
            if (h[c]) n++;
        return n;
    endfunction

    function automatic logic [63:0] stream(input logic [HW-1:0] h, input int from,
                                           input int n, input int stride);
        logic [63:0] s = '0;
        for (int i = 0; i < n; i++)
            s = {s[62:0], h[from + i * stride]};
        return s;
    endfunction

    // Reference MLT-3 walk over strobe samples; returns mismatching samples.
    function automatic int mlt_err(input logic [HW-1:0] b, input logic [HW-1:0] p,
                                   input logic [HW-1:0] n, input int from, input int to,
                                   input int stride);
        int lvl = 0;
        int nxt = 1;
        int errs = 0;
        for (int c = from; c < to; c += stride) begin
            if (b[c]) begin
                if (lvl == 0) lvl = nxt;
                else begin
                    nxt = -lvl;
                    lvl = 0;
                end
            end
            if (p[c] !== (lvl == 1) || n[c] !== (lvl == -1)) errs++;
        end
        return errs;
    endfunction

    initial begin
        int r, r2, rb, start, a, a1, a2, a3, ab, t, errs;
        logic [1:0] pn_tab [4];
        pn_tab = '{2'b10, 2'b00, 2'b01, 2'b00};

        rst_a = 1'b1; rst_b = 1'b1;
        valid_b = 1'b0; last_b = 1'b0; data_b = 8'h00;
        feed_a();

        // Reset state
        repeat (3) step();
        check("rst_linep",    64'(h_p_a[cyc-1]),   64'd0);
        check("rst_linen",    64'(h_n_a[cyc-1]),   64'd0);
        check("rst_ready",    64'(h_rdy_a[cyc-1]), 64'd0);
        check("rst_active",   64'(h_act_a[cyc-1]), 64'd0);
        check("rst_underrun", 64'(h_und_a[cyc-1]), 64'd0);
        check("rst_bitmon",   64'(h_bit_a[cyc-1]), 64'd1);
        check("rst_b_bitmon", 64'(h_bit_b[cyc-1]), 64'd1);

        // Idle line after reset: all ones, MLT-3 cycling
        rst_a = 1'b0;
        r = cyc;
        repeat (8) step();
        errs = 0;
        for (int i = 0; i < 8; i++)
            if ({h_p_a[r+i], h_n_a[r+i]} !== pn_tab[i % 4]) errs++;
        check("idle_pn_seq",   64'(errs), 64'd0);
        check("idle_bits",     64'(count_ones(h_bit_a, r, cyc)), 64'd8);
        check("idle_inactive", 64'(count_ones(h_act_a, r, cyc)), 64'd0);

        // Single byte 0x5A, last
        q_a.push_back('{d: 8'h5A, l: 1'b1});
        feed_a();
        start = cyc;
        repeat (60) step();
        a = find_first(h_act_a, start, cyc);
        check("t2_j_seen", 64'(a >= 0), 64'd1);
        if (a < 0) a = start;
        check("t2_stream",    stream(h_bit_a, a, 30, 1), 64'(FRAME_5A));
        check("t2_active",    64'(count_ones(h_act_a, start, cyc)), 64'd30);
        check("t2_ready_cnt", 64'(count_ones(h_rdy_a, start, cyc)), 64'd1);
        check("t2_ready_at",  64'(find_first(h_rdy_a, start, cyc)), 64'(a + 9));
        check("t2_idle_after", stream(h_bit_a, a + 30, 5, 1), 64'h1F);

        // Two-byte frame 0x00,0xFF then 0x5A with InValid held throughout
        q_a.push_back('{d: 8'h00, l: 1'b0});
        q_a.push_back('{d: 8'hFF, l: 1'b1});
        q_a.push_back('{d: 8'h5A, l: 1'b1});
        feed_a();
        start = cyc;
        repeat (110) step();
        a1 = find_first(h_act_a, start, cyc);
        check("t3_j_seen", 64'(a1 >= 0), 64'd1);
        if (a1 < 0) a1 = start;
        check("t3_stream",   stream(h_bit_a, a1, 40, 1), 64'(FRAME_00FF));
        check("t3_active",   64'(count_ones(h_act_a, a1, a1 + 41)), 64'd40);
        check("t3_rdy1_at",  64'(find_first(h_rdy_a, start, cyc)), 64'(a1 + 9));
        check("t3_rdy2_at",  64'(find_first(h_rdy_a, a1 + 10, cyc)), 64'(a1 + 19));
        a2 = find_first(h_act_a, a1 + 40, cyc);
        check("t3_gap",       64'(a2 - (a1 + 40)), 64'd10);
        check("t3_gap_bits",  stream(h_bit_a, a1 + 40, 10, 1), 64'h3FF);
        if (a2 < 0) a2 = a1 + 50;
        check("t3_next_stream", stream(h_bit_a, a2, 30, 1), 64'(FRAME_5A));
        check("t3_rdy3_at",  64'(find_first(h_rdy_a, a2, cyc)), 64'(a2 + 9));

        // Underrun: 0x12 not last, nothing offered at the next acceptance
        q_a.push_back('{d: 8'h12, l: 1'b0});
        feed_a();
        start = cyc;
        repeat (60) step();
        a = find_first(h_act_a, start, cyc);
        check("t4_j_seen", 64'(a >= 0), 64'd1);
        if (a < 0) a = start;
        check("t4_stream",    stream(h_bit_a, a, 35, 1), 64'(FRAME_12U));
        check("t4_und_cnt",   64'(count_ones(h_und_a, start, cyc)), 64'd1);
        check("t4_und_at",    64'(find_first(h_und_a, start, cyc)), 64'(a + 19));
        check("t4_ready_cnt", 64'(count_ones(h_rdy_a, start, cyc)), 64'd2);
        check("t4_active",    64'(count_ones(h_act_a, start, cyc)), 64'd35);
        check("t4_idle_after", stream(h_bit_a, a + 35, 5, 1), 64'h1F);
        check("mlt_a_run1",   64'(mlt_err(h_bit_a, h_p_a, h_n_a, r, cyc, 1)), 64'd0);

        // Reset while the high data nibble is on the line
        q_a.push_back('{d: 8'h33, l: 1'b1});
        feed_a();
        a = -1;
        for (int i = 0; i < 40 && a < 0; i++) begin
            step();
            if (h_act_a[cyc-1]) a = cyc - 1;
        end
        check("t5_j_seen", 64'(a >= 0), 64'd1);
        if (a < 0) a = cyc;
        t = 0;
        while (cyc < a + 17 && t < 40) begin
            step();
            t++;
        end
        rst_a = 1'b1;
        q_a.push_back('{d: 8'h5A, l: 1'b1});
        feed_a();
        step();
        check("t5_linep",  64'(h_p_a[cyc-1]),   64'd0);
        check("t5_linen",  64'(h_n_a[cyc-1]),   64'd0);
        check("t5_active", 64'(h_act_a[cyc-1]), 64'd0);
        check("t5_bitmon", 64'(h_bit_a[cyc-1]), 64'd1);
        check("t5_ready",  64'(h_rdy_a[cyc-1]), 64'd0);
        rst_a = 1'b0;
        r2 = cyc;
        repeat (60) step();
        a3 = find_first(h_act_a, r2, cyc);
        check("t5_restart_at", 64'(a3), 64'(r2 + 10));
        check("t5_idle_bits",  stream(h_bit_a, r2, 10, 1), 64'h3FF);
        if (a3 < 0) a3 = r2 + 10;
        check("t5_stream",     stream(h_bit_a, a3, 30, 1), 64'(FRAME_5A));
        check("mlt_a_run2",    64'(mlt_err(h_bit_a, h_p_a, h_n_a, r2, cyc, 1)), 64'd0);

        // BIT_DIV=3, byte 0x5A
        data_b = 8'h5A; last_b = 1'b1; valid_b = 1'b1;
        rst_b = 1'b0;
        rb = cyc;
        repeat (190) step();
        ab = find_first(h_act_b, rb, cyc);
        check("t6_j_at", 64'(ab), 64'(rb + 32));
        if (ab < 0) ab = rb + 32;
        check("t6_stream", stream(h_bit_b, ab, 30, 3), 64'(FRAME_5A));
        errs = 0;
        for (int i = 0; i < 30; i++)
            if (h_bit_b[ab+3*i+1] !== h_bit_b[ab+3*i] || h_bit_b[ab+3*i+2] !== h_bit_b[ab+3*i]) errs++;
        check("t6_bit_hold",  64'(errs), 64'd0);
        check("t6_active",    64'(count_ones(h_act_b, rb, cyc)), 64'd90);
        check("t6_ready_cnt", 64'(count_ones(h_rdy_b, rb, cyc)), 64'd1);
        check("t6_ready_at",  64'(find_first(h_rdy_b, rb, cyc)), 64'(ab + 27));
        errs = 0;
        for (int c = rb + 1; c < cyc; c++)
            if ({h_p_b[c], h_n_b[c], h_bit_b[c]} !== {h_p_b[c-1], h_n_b[c-1], h_bit_b[c-1]}
                && ((c - rb + 1) % 3) != 0) errs++;
        check("t6_change_on_strobe", 64'(errs), 64'd0);
        check("mlt_b", 64'(mlt_err(h_bit_b, h_p_b, h_n_b, rb + 2, cyc, 3)), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
